exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, operand/result width; SHALL be a power of two >= 4.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation offered this cycle.
REQ-005 in_ready  output  1  unit can accept; SHALL be high exactly when state is IDLE.
REQ-006 op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 SLL, 111 SRL.
REQ-007 rd_in  input  3  destination register index.
REQ-008 a, b  input  DATA_WIDTH  operands, driven by register-file read ports r1/r2.
REQ-009 wr_en  output  1  register-file write strobe.
REQ-010 rd  output  3  register-file write index.
REQ-011 din  output  DATA_WIDTH  register-file write data.
REQ-012 zero, carry  output  1 each  result flags of the last completed operation.

Function
REQ-013 Accept SHALL occur on an edge where in_valid && in_ready; a, b, op and rd_in SHALL be captured at that edge.
REQ-014 in_valid while in_ready is low SHALL be ignored, with no capture and no side effects.
REQ-015 States SHALL be IDLE and MUL; IDLE->MUL on accepting op=101; MUL->IDLE on the edge completing the last iteration; all other accepts stay in IDLE.
REQ-016 Single-cycle ops (all except MUL) accepted at edge N SHALL present wr_en/rd/din/flags during the cycle following edge N; back-to-back accepts every cycle SHALL be supported.
REQ-017 MUL SHALL be shift-add, one multiplier bit per cycle; iteration edges are N+1..N+DATA_WIDTH, and the result is presented in the cycle after edge N+DATA_WIDTH, with in_ready already high in that cycle.
REQ-018 wr_en SHALL be a one-cycle pulse per completed operation and SHALL be 0 when the captured rd_in == 0; flags SHALL still update.
REQ-019 rd and din SHALL hold their last values when wr_en is 0.
REQ-020 ADD: din = (a+b) mod 2^DATA_WIDTH; carry = carry-out.
REQ-021 SUB: din = (a-b) mod 2^DATA_WIDTH; carry = 1 iff a < b (unsigned borrow).
REQ-022 AND/OR/XOR: bitwise; carry = 0.
REQ-023 SLL/SRL: logical shift of a by b mod DATA_WIDTH with zero fill; carry = 0.
REQ-024 MUL: din = low DATA_WIDTH bits of unsigned a*b; carry = 1 iff the high half is nonzero.
REQ-025 zero SHALL be 1 iff din == 0, updated with din.
REQ-026 Flags SHALL change only on the edge that presents a completed result.

Reset
REQ-027 rst high at an edge SHALL force: state IDLE, wr_en 0, rd 0, din 0, zero 0, carry 0, and the MUL iteration counter and accumulator cleared.
REQ-028 rst SHALL take priority over accept and iteration; an in-progress MUL SHALL be aborted with no wr_en pulse.
REQ-029 in_ready SHALL be high in the first cycle after rst deasserts.

Verification (DATA_WIDTH=8)
REQ-030 ADD a=F0 b=20 rd_in=3 accepted at edge N -> next cycle: wr_en=1, rd=3, din=10, carry=1, zero=0; following cycle: wr_en=0.
REQ-031 SUB a=05 b=05 rd_in=2, then SUB a=03 b=05 next cycle -> din=00 zero=1 carry=0, then din=FE carry=1 zero=0 on consecutive cycles.
REQ-032 MUL a=0D b=0B rd_in=1 at edge N -> in_ready low cycles N+1..N+8; wr_en=1, din=8F, carry=0 in the cycle after edge N+8; an ADD offered during busy is not executed.
REQ-033 MUL a=FF b=FF rd_in=4 -> din=01, carry=1, zero=0.
REQ-034 rst high at the 4th MUL iteration edge -> no wr_en pulse, din=00, flags 0, in_ready=1 in the next cycle.
REQ-035 XOR a=5A b=5A rd_in=0 -> wr_en stays 0, zero=1, din holds its prior value.

Source files
------------

// File: rtl/exec_unit.sv
// Register-file execute unit: single-cycle ALU ops plus a bit-serial shift-add multiplier.
// Latency: 1 cycle for ALU ops; DATA_WIDTH+1 cycles for MUL (result in the cycle after the last iteration).
// Backpressure: in_ready drops while a MUL iterates; offers made while busy are dropped, never queued.
module exec_unit #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [2:0]            rd_in,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  wr_en,
    output logic [2:0]            rd,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  zero,
    output logic                  carry
);

    localparam int SHW = $clog2(DATA_WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] val;
        logic                  carry;
    } alu_res_t;

    state_t                    state_q, state_d;
    logic [SHW-1:0]            cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0]   mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*DATA_WIDTH-1:0]   acc_q, acc_d;
    logic [2:0]                mul_rd_q, mul_rd_d;
    logic                      wr_en_q, wr_en_d;
    logic [2:0]                rd_q, rd_d;
    logic [DATA_WIDTH-1:0]     din_q, din_d;
    logic                      zero_q, zero_d;
    logic                      carry_q, carry_d;

    logic [DATA_WIDTH:0]       sum_ext;
    logic [SHW-1:0]            shamt;
    alu_res_t                  alu;
    logic [2*DATA_WIDTH-1:0]   acc_step;
    logic                      mul_last;

    logic                      pres;
    logic [2:0]                pres_rd;
    logic [DATA_WIDTH-1:0]     pres_val;
    logic                      pres_carry;

    assign in_ready = (state_q == IDLE);
    assign wr_en    = wr_en_q;
    assign rd       = rd_q;
    assign din      = din_q;
    assign zero     = zero_q;
    assign carry    = carry_q;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign shamt    = b[SHW-1:0];
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mul_last = (cnt_q == SHW'(DATA_WIDTH - 1));

    always_comb begin
        alu = '0;
        case (op)
            OP_ADD: begin
                alu.val   = sum_ext[DATA_WIDTH-1:0];
                alu.carry = sum_ext[DATA_WIDTH];
            end
            OP_SUB: begin
                alu.val   = a - b;
                alu.carry = (a < b);
            end
            OP_AND: alu.val = a & b;
            OP_OR:  alu.val = a | b;
            OP_XOR: alu.val = a ^ b;
            OP_SLL: alu.val = a << shamt;
            OP_SRL: alu.val = a >> shamt;
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        mul_rd_d   = mul_rd_q;
        wr_en_d    = 1'b0;
        rd_d       = rd_q;
        din_d      = din_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        pres       = 1'b0;
        pres_rd    = '0;
        pres_val   = '0;
        pres_carry = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        state_d  = MUL;
                        mcand_d  = {{DATA_WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        mul_rd_d = rd_in;
                    end else begin
                        pres       = 1'b1;
                        pres_rd    = rd_in;
                        pres_val   = alu.val;
                        pres_carry = alu.carry;
                    end
                end
            end
            MUL: begin
                // One multiplier bit per edge; the final edge also publishes the product.
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (mul_last) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    pres       = 1'b1;
                    pres_rd    = mul_rd_q;
                    pres_val   = acc_step[DATA_WIDTH-1:0];
                    pres_carry = |acc_step[2*DATA_WIDTH-1:DATA_WIDTH];
                end
            end
            default: state_d = IDLE;
        endcase

        // Register 0 is never written, but flags still reflect the discarded result.
        if (pres) begin
            wr_en_d = (pres_rd != 3'd0);
            zero_d  = (pres_val == '0);
            carry_d = pres_carry;
            if (pres_rd != 3'd0) begin
                rd_d  = pres_rd;
                din_d = pres_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            mul_rd_q <= '0;
            wr_en_q  <= 1'b0;
            rd_q     <= '0;
            din_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            mul_rd_q <= mul_rd_d;
            wr_en_q  <= wr_en_d;
            rd_q     <= rd_d;
            din_q    <= din_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: a behavioural model fills a scoreboard at drive time,
// entries are popped and compared in the cycle the unit presents its result.
module tb_exec_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [2:0] rd_in;
    logic [7:0] a;
    logic [7:0] b;
    logic       wr_en;
    logic [2:0] rd;
    logic [7:0] din;
    logic       zero;
    logic       carry;

    exec_unit #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rd_in    (rd_in),
        .a        (a),
        .b        (b),
        .wr_en    (wr_en),
        .rd       (rd),
        .din      (din),
        .zero     (zero),
        .carry    (carry)
    );

    typedef struct {
        logic       we;
        logic [2:0] rd;
        logic [7:0] din;
        logic       zero;
        logic       carry;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [2:0] mdl_rd = 3'd0;
    logic [7:0] mdl_din = 8'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on widened operands, plus register-hold tracking.
    task automatic push(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [2:0] r);
        exp_t        e;
        logic [15:0] w;
        logic [7:0]  res;
        logic        c;
        w = 16'd0;
        c = 1'b0;
        case (o)
            3'd0: begin w = {8'd0, x} + {8'd0, y}; res = w[7:0]; c = w[8]; end
            3'd1: begin res = x - y; c = (x < y); end
            3'd2: res = x & y;
            3'd3: res = x | y;
            3'd4: res = x ^ y;
            3'd5: begin w = {8'd0, x} * {8'd0, y}; res = w[7:0]; c = (w[15:8] != 8'd0); end
            3'd6: res = x << (y % 8);
            default: res = x >> (y % 8);
        endcase
        e.we    = (r != 3'd0);
        e.zero  = (res == 8'd0);
        e.carry = c;
        if (r != 3'd0) begin
            mdl_rd  = r;
            mdl_din = res;
        end
        e.rd  = mdl_rd;
        e.din = mdl_din;
        sb.push_back(e);
    endtask

    task automatic offer(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [2:0] r, input bit expect_result);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        rd_in    = r;
        if (expect_result) push(o, x, y, r);
    endtask

    task automatic expect_out(input string tag);
        exp_t e;
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_we"},    32'(wr_en), 32'(e.we));
            check({tag, "_rd"},    32'(rd),    32'(e.rd));
            check({tag, "_din"},   32'(din),   32'(e.din));
            check({tag, "_zero"},  32'(zero),  32'(e.zero));
            check({tag, "_carry"}, 32'(carry), 32'(e.carry));
        end
    endtask

    logic [2:0] single_ops [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 3'd0;
        rd_in    = 3'd0;
        a        = 8'd0;
        b        = 8'd0;

        // Reset state
        tick();
        tick();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_rd",    32'(rd),    32'd0);
        check("rst_din",   32'(din),   32'd0);
        check("rst_zero",  32'(zero),  32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        rst = 1'b0;
        tick();
        check("rdy_after_rst", 32'(in_ready), 32'd1);

        // ADD with carry-out, then wr_en must drop
        offer(3'd0, 8'hF0, 8'h20, 3'd3, 1'b1);
        tick();
        in_valid = 1'b0;
        expect_out("add_f0_20");
        check("add_din_val", 32'(din), 32'h10);
        tick();
        check("add_pulse_end", 32'(wr_en), 32'd0);
        check("add_din_hold",  32'(din),   32'h10);

        // Back-to-back SUBs: equal operands then borrow
        offer(3'd1, 8'h05, 8'h05, 3'd2, 1'b1);
        tick();
        check("sub_b2b_ready", 32'(in_ready), 32'd1);
        offer(3'd1, 8'h03, 8'h05, 3'd2, 1'b1);
        expect_out("sub_eq");
        tick();
        in_valid = 1'b0;
        expect_out("sub_borrow");
        check("sub_borrow_din", 32'(din), 32'hFE);

        // MUL 0D*0B with an ADD offered while busy (must be dropped)
        offer(3'd5, 8'h0D, 8'h0B, 3'd1, 1'b1);
        tick();
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("mul1_busy%0d", i), 32'(in_ready), 32'd0);
            check($sformatf("mul1_we%0d", i),   32'(wr_en),    32'd0);
            if (i >= 2 && i <= 4) offer(3'd0, 8'h01, 8'h01, 3'd5, 1'b0);
            else in_valid = 1'b0;
            tick();
        end
        check("mul1_ready_on_result", 32'(in_ready), 32'd1);
        expect_out("mul_0d_0b");
        check("mul1_din", 32'(din), 32'h8F);
        tick();
        check("mul1_pulse_end", 32'(wr_en), 32'd0);
        check("mul1_add_dropped", 32'(rd), 32'd1);

        // MUL FF*FF: overflow into high half
        offer(3'd5, 8'hFF, 8'hFF, 3'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("mul2_busy%0d", i), 32'(in_ready), 32'd0);
            tick();
        end
        expect_out("mul_ff_ff");

        // Reset on the 4th iteration edge aborts the multiply
        tick();
        offer(3'd5, 8'h07, 8'h09, 3'd6, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_we",    32'(wr_en),    32'd0);
        check("abort_din",   32'(din),      32'd0);
        check("abort_zero",  32'(zero),     32'd0);
        check("abort_carry", 32'(carry),    32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        mdl_rd  = 3'd0;
        mdl_din = 8'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("abort_quiet%0d", i), 32'(wr_en), 32'd0);
        end

        // XOR into register 0: flags update, write suppressed, din held
        offer(3'd0, 8'h12, 8'h34, 3'd7, 1'b1);
        tick();
        offer(3'd4, 8'h5A, 8'h5A, 3'd0, 1'b1);
        expect_out("add_12_34");
        tick();
        in_valid = 1'b0;
        expect_out("xor_rd0");
        check("xor_rd0_din_hold", 32'(din), 32'h46);

        // Shift amounts taken modulo the width
        offer(3'd6, 8'h81, 8'h09, 3'd3, 1'b1);
        tick();
        offer(3'd7, 8'h80, 8'h07, 3'd5, 1'b1);
        expect_out("sll_mod");
        tick();
        in_valid = 1'b0;
        expect_out("srl_7");

        // Back-to-back random single-cycle ops
        for (int i = 0; i < 24; i++) begin
            offer(single_ops[$urandom_range(0, 6)], 8'($urandom), 8'($urandom),
                  3'($urandom_range(0, 7)), 1'b1);
            tick();
            expect_out($sformatf("rand%0d", i));
        end
        in_valid = 1'b0;
        tick();
        check("rand_pulse_end", 32'(wr_en), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
